mult_sweep_ctrl: RTL and testbench
==================================

// Module: mult_sweep_ctrl
// PURPOSE
//  Sequencer and checker for the approx_32x32 multiplier. Sweeps every operand pair
//  over an OP_W-bit range, one pair per cycle. Compares each returned product to the
//  exact product and accumulates correct/wrong counts and the maximum absolute error.
//  Sits between a host/test harness and the multiplier; it replaces free-running
//  operand generation with a start/done controlled characterisation run.
// PARAMETERS
//  DATA_W  32  multiplier operand width; product width is 2*DATA_W
//  OP_W    8   swept operand width (1..DATA_W); operands are zero-extended to DATA_W
//  LAT     0   multiplier latency in cycles (0 = combinational)
//  CNT_W   32  width of the correct/wrong counters
// PORTS
//  clk              in   1         clock, all logic on rising edge
//  rst_n            in   1         synchronous reset, active low
//  start            in   1         begin sweep; sampled only in IDLE
//  abort            in   1         stop sweep; return to IDLE, no done pulse
//  precise_cfg      in   1         precision mode for the run; latched on start
//  mult_a           out  DATA_W    operand a to multiplier
//  mult_b           out  DATA_W    operand b to multiplier
//  mult_precise_en  out  1         precision enable to multiplier
//  mult_y           in   2*DATA_W  product from multiplier
//  busy             out  1         high in RUN and DRAIN
//  done             out  1         one-cycle pulse; counters final in that cycle
//  ok_cnt           out  CNT_W     pairs with mult_y == exact
//  err_cnt          out  CNT_W     pairs with mult_y != exact
//  max_abs_err      out  2*DATA_W  max |mult_y - exact| over the run
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state IDLE, all outputs 0, delay line flushed. Applies mid-run.
//  - FSM: IDLE -start-> RUN -last pair issued-> DRAIN (LAT cycles; skipped if LAT=0)
//    -> DONE (1 cycle, done=1) -> IDLE. abort in RUN/DRAIN -> IDLE next cycle. Counters hold.
//  - start at edge k in IDLE: clear counters and max, latch precise_cfg. RUN begins in cycle k+1.
//    start in any other state is ignored.
//  - Sweep order: a outer, b inner, both 0..2^OP_W-1. Pair (0,0) is driven in cycle k+1.
//    b wraps to 0 and a increments at b=2^OP_W-1. Pair (max,max) is last; each pair issued exactly once.
//    N = 2^(2*OP_W) issue cycles.
//  - mult_a/mult_b are 0 outside RUN. mult_precise_en is the latched cfg while busy, else 0.
//  - Exact product a*b is computed at full 2*DATA_W width and delayed LAT cycles with a
//    valid bit. The pair issued in cycle c is compared at the edge ending cycle c+LAT.
//    Counter update is visible in cycle c+LAT+1.
//  - abs error = (y>=exact) ? y-exact : exact-y, unsigned, 2*DATA_W wide.
//    max_abs_err updates only when the new value is strictly greater.
//  - Counters saturate at 2^CNT_W-1 and do not wrap.
//  - done is high in cycle k+N+LAT+1. ok_cnt+err_cnt == N there, unless saturated.
//  - abort and reset discard in-flight compares: the delay-line valid bits are cleared.
//  - abort and start in the same cycle while IDLE: abort wins, run does not start.
// STRUCTURE
//  - mult_ctrl_pkg: state enum {IDLE,RUN,DRAIN,DONE}, product/counter typedefs,
//    a saturating-increment function.
//  - Sub-module mult_pipe_delay: LAT-deep shift register of {valid, exact product}.
//    LAT=0 is a passthrough. FSM, sweep counters and checker stay in this module.
// TESTING
//  1 OP_W=2, LAT=0, exact model; pulse start -> done 17 cycles later, ok_cnt=16,
//    err_cnt=0, max_abs_err=0.
//  2 OP_W=2, model forces y[0]=0 -> err_cnt=4 (a,b in {1,3}), ok_cnt=12, max_abs_err=1.
//  3 Same as 2 with LAT=2 pipelined model -> identical counts, done 19 cycles after start.
//  4 OP_W=2, abort after 5 RUN cycles -> IDLE next cycle, no done, busy=0, mult_a=mult_b=0;
//    restart -> full 16-pair result.
//  5 start held high through RUN, precise_cfg toggled mid-run -> single run,
//    mult_precise_en constant.
//  6 rst_n low for 1 cycle mid-DRAIN -> all outputs 0 next cycle, no done;
//    new start gives correct counts.

Source files
------------

// File: rtl/mult_ctrl_pkg.sv
// Shared types and helpers for the multiplier sweep controller.
package mult_ctrl_pkg;

    // Controller states; the encoding is also exported on dbg_state.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Widest product / counter value the helpers operate on.
    localparam int MAX_W = 64;

    typedef logic [MAX_W-1:0] prod_t;
    typedef logic [31:0]      cnt_t;

    // Increment v, sticking at the all-ones value of a w-bit counter.
    function automatic prod_t sat_inc(input prod_t v, input int w);
        prod_t lim;
        lim = (w >= MAX_W) ? '1 : ((prod_t'(1) << w) - prod_t'(1));
        return (v >= lim) ? lim : v + prod_t'(1);
    endfunction

endpackage

// File: rtl/mult_pipe_delay.sv
// LAT-deep delay line for {valid, exact product}, matching the multiplier
// latency so each reference product meets the matching returned product.
// LAT = 0 is a plain passthrough.
module mult_pipe_delay #(
    parameter int W   = 64,
    parameter int LAT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    if (LAT == 0) begin : g_pass
        assign o_valid = i_valid;
        assign o_data  = i_data;
        logic w_unused;
        assign w_unused = ^{clk, rst_n, i_flush};
    end else begin : g_pipe
        logic [LAT-1:0] r_valid;
        logic [W-1:0]   r_data [LAT];

        // Valid bits shift toward the output; reset or flush drops everything in flight.
        always_ff @(posedge clk) begin
            if (!rst_n || i_flush) begin
                r_valid <= '0;
            end else begin
                for (int i = LAT - 1; i > 0; i--) r_valid[i] <= r_valid[i-1];
                r_valid[0] <= i_valid;
            end
        end

        // Product payload shifts unconditionally; it is qualified by the valid bits.
        always_ff @(posedge clk) begin
            for (int i = LAT - 1; i > 0; i--) r_data[i] <= r_data[i-1];
            r_data[0] <= i_data;
        end

        assign o_valid = r_valid[LAT-1];
        assign o_data  = r_data[LAT-1];
    end

endmodule

// File: rtl/mult_sweep_ctrl.sv
// Sweep sequencer and checker for the approx_32x32 multiplier. Drives every
// OP_W-bit operand pair once (a outer, b inner), compares each returned
// product with the exact one and keeps ok/err counts plus the max abs error.
// Handshake: start is sampled only in IDLE; abort in RUN/DRAIN returns to
// IDLE next cycle without a done pulse; done is a one-cycle pulse in which
// the counters are final.
module mult_sweep_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 8,
    parameter int LAT    = 0,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  precise_cfg,
    output logic [DATA_W-1:0]     mult_a,
    output logic [DATA_W-1:0]     mult_b,
    output logic                  mult_precise_en,
    input  logic [2*DATA_W-1:0]   mult_y,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      ok_cnt,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [2*DATA_W-1:0]   max_abs_err,
    output logic [1:0]            dbg_state
);

    localparam int PW = 2 * DATA_W;
    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [DW-1:0] DRAIN_INIT = (LAT > 0) ? DW'(LAT - 1) : '0;

    state_t           r_state;
    logic [OP_W-1:0]  r_a;
    logic [OP_W-1:0]  r_b;
    logic [DW-1:0]    r_drain;
    logic             r_pen;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_ok;
    logic [CNT_W-1:0] r_err;
    logic [PW-1:0]    r_max;

    logic             w_last;
    logic             w_start_go;
    logic             w_flush;
    logic             w_pipe_valid;
    logic [PW-1:0]    w_exact_in;
    logic [PW-1:0]    w_exact;
    logic [PW-1:0]    w_diff;
    logic             w_cmp;

    // Operand counters wrap back to zero after (max,max), so mult_a/mult_b
    // read zero everywhere outside RUN without extra gating.
    assign mult_a          = DATA_W'(r_a);
    assign mult_b          = DATA_W'(r_b);
    assign mult_precise_en = r_pen;
    assign busy            = r_busy;
    assign done            = r_done;
    assign ok_cnt          = r_ok;
    assign err_cnt         = r_err;
    assign max_abs_err     = r_max;
    assign dbg_state       = r_state;

    assign w_last     = (&r_a) & (&r_b);
    assign w_start_go = (r_state == ST_IDLE) & start & ~abort;
    assign w_flush    = abort & r_busy;
    assign w_exact_in = PW'(mult_a) * PW'(mult_b);

    mult_pipe_delay #(.W(PW), .LAT(LAT)) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_flush),
        .i_valid ((r_state == ST_RUN) & ~abort),
        .i_data  (w_exact_in),
        .o_valid (w_pipe_valid),
        .o_data  (w_exact)
    );

    // Control FSM: state, sweep counters, drain timer and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_drain <= '0;
            r_pen   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_go) begin
                        r_state <= ST_RUN;
                        r_a     <= '0;
                        r_b     <= '0;
                        r_pen   <= precise_cfg;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_a     <= '0;
                        r_b     <= '0;
                        r_pen   <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_b <= r_b + OP_W'(1);
                        if (&r_b) r_a <= r_a + OP_W'(1);
                        if (w_last) begin
                            if (LAT == 0) begin
                                r_state <= ST_DONE;
                                r_pen   <= 1'b0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_DRAIN;
                                r_drain <= DRAIN_INIT;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_pen   <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (r_drain == '0) begin
                        r_state <= ST_DONE;
                        r_pen   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain - DW'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // An aborted run drops the compare that would land on the abort edge.
    assign w_cmp  = w_pipe_valid & r_busy & ~abort;
    assign w_diff = (mult_y >= w_exact) ? (mult_y - w_exact) : (w_exact - mult_y);

    // Checker: saturating ok/err counts and running max of |y - exact|.
    always_ff @(posedge clk) begin
        if (!rst_n || w_start_go) begin
            r_ok  <= '0;
            r_err <= '0;
            r_max <= '0;
        end else if (w_cmp) begin
            if (mult_y == w_exact) r_ok  <= CNT_W'(sat_inc(prod_t'(r_ok), CNT_W));
            else                   r_err <= CNT_W'(sat_inc(prod_t'(r_err), CNT_W));
            if (w_diff > r_max) r_max <= w_diff;
        end
    end

endmodule

// File: tb/tb_mult_sweep_ctrl.sv
// Bench for mult_sweep_ctrl: three instances (LAT 0, LAT 2, LAT 1 with 3-bit
// saturating counters) share one stimulus stream; each gets its own
// emulated multiplier with the matching latency.
module tb_mult_sweep_ctrl;

  localparam int DATA_W = 32;
  localparam int OP_W   = 2;
  localparam int NP     = 1 << (2 * OP_W);
  localparam int NI     = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic precise_cfg = 1'b0;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  int          fault_mode = 0;
  logic [63:0] fault_mask = 64'd1;

  int   run_k = -1000;
  int   stop_cyc = 32'h7fff_ffff;
  logic exp_pen = 1'b0;

  logic [DATA_W-1:0] ma [NI];
  logic [DATA_W-1:0] mb [NI];
  logic              pe [NI];
  logic              bz [NI];
  logic              dn [NI];
  logic [63:0]       yv [NI];
  logic [63:0]       mx [NI];
  logic [31:0]       okv [NI];
  logic [31:0]       erv [NI];
  logic [1:0]        st [NI];
  logic [2:0]        ok_s;
  logic [2:0]        err_s;

  // expected entry: {ok[159:128], err[127:96], max[95:32], done_cycle[31:0]}
  logic [159:0] exp_q0[$];
  logic [159:0] exp_q1[$];
  logic [159:0] exp_q2[$];

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- emulated multiplier ----------------
  function automatic logic [63:0] mult_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic pen, input int mode,
                                             input logic [63:0] mask);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    if (pen || mode == 0) return p;
    if (mode == 1) return p & ~64'd1;
    if (mode == 2) return (a == b) ? p + mask : p;
    return ((a ^ b) & 32'd1) != 32'd0 ? (p ^ mask) : p;
  endfunction

  logic [63:0] lat2_s1, lat2_s2, lat1_s1;
  always @(posedge clk) begin
    lat2_s1 <= mult_model(ma[1], mb[1], pe[1], fault_mode, fault_mask);
    lat2_s2 <= lat2_s1;
    lat1_s1 <= mult_model(ma[2], mb[2], pe[2], fault_mode, fault_mask);
  end
  assign yv[0] = mult_model(ma[0], mb[0], pe[0], fault_mode, fault_mask);
  assign yv[1] = lat2_s2;
  assign yv[2] = lat1_s1;
  assign okv[2] = {29'd0, ok_s};
  assign erv[2] = {29'd0, err_s};

  mult_sweep_ctrl #(.DATA_W(DATA_W), .OP_W(OP_W), .LAT(0), .CNT_W(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .precise_cfg(precise_cfg),
    .mult_a(ma[0]), .mult_b(mb[0]), .mult_precise_en(pe[0]), .mult_y(yv[0]),
    .busy(bz[0]), .done(dn[0]), .ok_cnt(okv[0]), .err_cnt(erv[0]),
    .max_abs_err(mx[0]), .dbg_state(st[0]));

  mult_sweep_ctrl #(.DATA_W(DATA_W), .OP_W(OP_W), .LAT(2), .CNT_W(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .precise_cfg(precise_cfg),
    .mult_a(ma[1]), .mult_b(mb[1]), .mult_precise_en(pe[1]), .mult_y(yv[1]),
    .busy(bz[1]), .done(dn[1]), .ok_cnt(okv[1]), .err_cnt(erv[1]),
    .max_abs_err(mx[1]), .dbg_state(st[1]));

  mult_sweep_ctrl #(.DATA_W(DATA_W), .OP_W(OP_W), .LAT(1), .CNT_W(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .precise_cfg(precise_cfg),
    .mult_a(ma[2]), .mult_b(mb[2]), .mult_precise_en(pe[2]), .mult_y(yv[2]),
    .busy(bz[2]), .done(dn[2]), .ok_cnt(ok_s), .err_cnt(err_s),
    .max_abs_err(mx[2]), .dbg_state(st[2]));

  function automatic int lat_of(input int i);
    case (i)
      0: return 0;
      1: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] sat_of(input int i);
    return (i == 2) ? 32'd7 : 32'hffff_ffff;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s inst%0d cyc=%0d actual=0x%0h required=0x%0h", name, inst, cyc, act, req);
    end
  endtask

  task automatic fail_event(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s cyc=%0d", name, cyc);
  endtask

  function automatic int q_size(input int i);
    case (i)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic q_pop(input int i, output logic [159:0] e);
    case (i)
      0: e = exp_q0.pop_front();
      1: e = exp_q1.pop_front();
      default: e = exp_q2.pop_front();
    endcase
  endtask

  // Reference model: walk every pair at the behavioural level and tally.
  task automatic push_expected(input int k, input logic pen);
    logic [31:0] ok, er, okc, erc;
    logic [63:0] mxe, y, ex, d;
    logic [159:0] e;
    ok = 0; er = 0; mxe = 0;
    for (int a = 0; a < (1 << OP_W); a++) begin
      for (int b = 0; b < (1 << OP_W); b++) begin
        ex = 64'(a) * 64'(b);
        y  = mult_model(32'(a), 32'(b), pen, fault_mode, fault_mask);
        if (y == ex) ok = ok + 1; else er = er + 1;
        d = (y >= ex) ? y - ex : ex - y;
        if (d > mxe) mxe = d;
      end
    end
    for (int i = 0; i < NI; i++) begin
      okc = (ok > sat_of(i)) ? sat_of(i) : ok;
      erc = (er > sat_of(i)) ? sat_of(i) : er;
      e = {okc, erc, mxe, 32'(k + NP + lat_of(i) + 1)};
      case (i)
        0: exp_q0.push_back(e);
        1: exp_q1.push_back(e);
        default: exp_q2.push_back(e);
      endcase
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    int last_busy, idx;
    bit exp_busy, in_sweep;
    logic [159:0] e;
    if (mon_en) begin
      for (int i = 0; i < NI; i++) begin
        last_busy = run_k + NP + lat_of(i);
        if (stop_cyc < last_busy) last_busy = stop_cyc;
        exp_busy = (cyc >= run_k + 1) && (cyc <= last_busy);
        idx = cyc - run_k - 1;
        in_sweep = exp_busy && (idx < NP);
        check("busy", i, 64'(bz[i]), 64'(exp_busy));
        check("precise_en", i, 64'(pe[i]), exp_busy ? 64'(exp_pen) : 64'd0);
        check("mult_a", i, 64'(ma[i]), in_sweep ? 64'(idx >> OP_W) : 64'd0);
        check("mult_b", i, 64'(mb[i]), in_sweep ? 64'(idx & ((1 << OP_W) - 1)) : 64'd0);
        if (dn[i]) begin
          if (q_size(i) == 0) begin
            fail_event($sformatf("spurious_done inst%0d", i));
          end else begin
            q_pop(i, e);
            check("ok_cnt", i, 64'(okv[i]), 64'(e[159:128]));
            check("err_cnt", i, 64'(erv[i]), 64'(e[127:96]));
            check("max_abs_err", i, mx[i], e[95:32]);
            check("done_cycle", i, 64'(cyc), 64'(e[31:0]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run(input logic pen, input int mode, input logic [63:0] mask);
    fault_mode = mode;
    fault_mask = mask;
    precise_cfg = pen;
    start = 1'b1;
    run_k = cyc;
    stop_cyc = 32'h7fff_ffff;
    exp_pen = pen;
    push_expected(cyc, pen);
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while ((bz[0] || bz[1] || bz[2] || dn[0] || dn[1] || dn[2] ||
            exp_q0.size() != 0 || exp_q1.size() != 0 || exp_q2.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      fail_event("done_timeout");
      exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check({tag, "_ok"}, i, 64'(okv[i]), 64'd0);
      check({tag, "_err"}, i, 64'(erv[i]), 64'd0);
      check({tag, "_max"}, i, mx[i], 64'd0);
      check({tag, "_done"}, i, 64'(dn[i]), 64'd0);
      check({tag, "_busy"}, i, 64'(bz[i]), 64'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k, hold;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    mon_en = 1'b1;
    check_zero("reset");
    tick();

    // exact multiplier
    begin_run(1'b0, 0, 64'd1);
    tick(); start = 1'b0;
    wait_quiet(100);

    // LSB forced to zero
    tick();
    begin_run(1'b0, 1, 64'd1);
    tick(); start = 1'b0;
    wait_quiet(100);

    // abort after 5 RUN cycles, then restart
    tick();
    begin_run(1'b0, 2, 64'($urandom_range(1, 255)));
    tick(); start = 1'b0;
    repeat (4) tick();
    abort = 1'b1;
    stop_cyc = cyc;
    void'(exp_q0.pop_back()); void'(exp_q1.pop_back()); void'(exp_q2.pop_back());
    tick(); abort = 1'b0;
    repeat (6) tick();
    begin_run(1'b0, 2, fault_mask);
    tick(); start = 1'b0;
    wait_quiet(100);

    // start held through RUN, precise_cfg toggled mid-run
    tick();
    begin_run(1'b1, 3, 64'($urandom_range(1, 255)));
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (j == 5) precise_cfg = ~precise_cfg;
    end
    start = 1'b0;
    wait_quiet(100);

    // abort and start together in IDLE: abort wins
    tick();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (5) tick();

    // reset for one cycle while the LAT=2 instance is draining
    begin_run(1'b0, 1, 64'd1);
    k = run_k;
    tick(); start = 1'b0;
    while (cyc < k + NP + 2) tick();
    rst_n = 1'b0;
    stop_cyc = cyc;
    tick();
    rst_n = 1'b1;
    exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
    check_zero("midrun_reset");
    tick();
    begin_run(1'b0, 1, 64'd1);
    tick(); start = 1'b0;
    wait_quiet(100);

    // randomized runs
    repeat (8) begin
      repeat ($urandom_range(1, 3)) tick();
      hold = $urandom_range(1, 4);
      begin_run(1'($urandom_range(0, 1)), $urandom_range(0, 3), 64'($urandom_range(1, 255)));
      repeat (hold) tick();
      start = 1'b0;
      wait_quiet(100);
    end

    repeat (3) tick();
    for (int i = 0; i < NI; i++) check("leftover_expected", i, 64'(q_size(i)), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
